rx_uart: RTL and testbench

- UART receiver; the receive-side counterpart of the team's 16x-oversampled transmitter, matching its frame format.
- Receives 1 start bit, DBIT data bits (LSB first), an optional parity bit, and 1 stop bit.
- Samples the serial line at mid-bit using the shared baud tick generator (i_s_tick, 16 ticks per bit).
- Delivers each byte with a one-cycle done pulse and error flags to the downstream interface/ALU logic.

---
 rtl/rx_uart.sv | 178 +++++++++++++++++
 tb/tb_rx_uart.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rx_uart.sv
// UART receiver, 16x oversampled. Frame format: 1 start bit, DBIT data bits
// (LSB first), an optional parity bit and a stop bit of SB_TICK ticks.
// Every bit is sampled at its midpoint. Each completed frame, good or bad,
// produces a one-clock done pulse together with its data and error flags.
module rx_uart #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int PAR_EN  = 0,
   parameter int PAR_ODD = 0
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_rx,
   input  logic            i_s_tick,
   output logic [DBIT-1:0] o_data,
   output logic            o_rx_done_tick,
   output logic            o_frame_err,
   output logic            o_parity_err,
   output logic            o_busy
);

   // Tick counter must reach SB_TICK-1, which needs 5 bits for stop bits longer than 1.
   localparam int TW = (SB_TICK > 16) ? 5 : 4;
   localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [TW-1:0] T_MID  = TW'(7);
   localparam logic [TW-1:0] T_END  = TW'(15);
   localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] N_LAST = BW'(DBIT - 1);
   localparam logic          HAS_PAR = (PAR_EN != 0);
   localparam logic          ODD     = (PAR_ODD != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [TW-1:0]   s_reg, s_n;
   logic [BW-1:0]   n_reg, n_n;
   logic [DBIT-1:0] sh_reg, sh_n;
   logic            perr_pend, perr_pend_n;
   logic [DBIT-1:0] data_n;
   logic            done_n, ferr_n, perr_n;

   logic            rx_p0, rx_p1;
   logic            rx_s;

   assign rx_s = rx_p1;

   // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= i_rx;
         rx_p1 <= rx_p0;
      end
   end

   // State, counters, shift register and all registered outputs.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state          <= IDLE;
         s_reg          <= '0;
         n_reg          <= '0;
         sh_reg         <= '0;
         perr_pend      <= 1'b0;
         o_data         <= '0;
         o_rx_done_tick <= 1'b0;
         o_frame_err    <= 1'b0;
         o_parity_err   <= 1'b0;
         o_busy         <= 1'b0;
      end else begin
         state          <= state_n;
         s_reg          <= s_n;
         n_reg          <= n_n;
         sh_reg         <= sh_n;
         perr_pend      <= perr_pend_n;
         o_data         <= data_n;
         o_rx_done_tick <= done_n;
         o_frame_err    <= ferr_n;
         o_parity_err   <= perr_n;
         o_busy         <= (state_n != IDLE);
      end
   end

   // Next-state logic: counters only move on baud ticks; outputs hold unless a frame completes.
   always_comb begin
      state_n     = state;
      s_n         = s_reg;
      n_n         = n_reg;
      sh_n        = sh_reg;
      perr_pend_n = perr_pend;
      data_n      = o_data;
      done_n      = 1'b0;
      ferr_n      = o_frame_err;
      perr_n      = o_parity_err;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               s_n     = '0;
            end
         end

         START: begin
            if (i_s_tick) begin
               if (s_reg == T_MID) begin
                  if (!rx_s) begin
                     state_n     = DATA;
                     s_n         = '0;
                     n_n         = '0;
                     perr_pend_n = 1'b0;
                  end else begin
                     // Line went back high before mid start bit: treat as a glitch.
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s_reg + 1'b1;
               end
            end
         end

         DATA: begin
            if (i_s_tick) begin
               if (s_reg == T_END) begin
                  s_n  = '0;
                  sh_n = {rx_s, sh_reg[DBIT-1:1]};
                  if (n_reg == N_LAST) begin
                     state_n = HAS_PAR ? PARITY : STOP;
                  end else begin
                     n_n = n_reg + 1'b1;
                  end
               end else begin
                  s_n = s_reg + 1'b1;
               end
            end
         end

         PARITY: begin
            if (i_s_tick) begin
               if (s_reg == T_END) begin
                  s_n         = '0;
                  perr_pend_n = rx_s ^ (^sh_reg) ^ ODD;
                  state_n     = STOP;
               end else begin
                  s_n = s_reg + 1'b1;
               end
            end
         end

         STOP: begin
            if (i_s_tick) begin
               if (s_reg == T_STOP) begin
                  data_n  = sh_reg;
                  ferr_n  = ~rx_s;
                  perr_n  = perr_pend;
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  s_n = s_reg + 1'b1;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: one instance without parity, one with even parity.
// Serial frames are driven at 16 baud ticks per bit, ticks every 16 clocks.
module tb_rx_uart;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic [3:0] tcnt;

   logic       rx_a, rx_p;
   logic [7:0] data_a, data_p;
   logic       done_a, done_p;
   logic       ferr_a, ferr_p;
   logic       perr_a, perr_p;
   logic       busy_a, busy_p;

   int n_vec = 0;
   int n_bad = 0;
   int cnt_a = 0;
   int cnt_p = 0;
   int d0;

   rx_uart #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) u_dut_a (
      .i_clock        (clk),
      .i_reset        (rst_n),
      .i_rx           (rx_a),
      .i_s_tick       (tick),
      .o_data         (data_a),
      .o_rx_done_tick (done_a),
      .o_frame_err    (ferr_a),
      .o_parity_err   (perr_a),
      .o_busy         (busy_a)
   );

   rx_uart #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) u_dut_p (
      .i_clock        (clk),
      .i_reset        (rst_n),
      .i_rx           (rx_p),
      .i_s_tick       (tick),
      .o_data         (data_p),
      .o_rx_done_tick (done_p),
      .o_frame_err    (ferr_p),
      .o_parity_err   (perr_p),
      .o_busy         (busy_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Baud tick: one clock wide, every 16 clocks, changing on the falling edge.
   initial tcnt = 4'd0;
   always @(negedge clk) tcnt <= tcnt + 4'd1;
   assign tick = (tcnt == 4'd15);

   // Count done pulses of each instance.
   always @(posedge clk) begin
      if (done_a) cnt_a <= cnt_a + 1;
      if (done_p) cnt_p <= cnt_p + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!tick) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit sel, input logic b, input int n);
      if (sel) rx_p = b;
      else     rx_a = b;
      wait_ticks(n);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                             input logic stp, input int stp_ticks);
      drive(sel, 1'b0, 16);
      for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
      if (sel) drive(sel, par, 16);
      drive(sel, stp, stp_ticks);
   endtask

   initial begin
      rst_n = 1'b0;
      rx_a  = 1'b1;
      rx_p  = 1'b1;
      repeat (4) @(negedge clk);

      chk("rst_data",  {24'd0, data_a}, 32'h0);
      chk("rst_done",  {31'd0, done_a}, 32'h0);
      chk("rst_ferr",  {31'd0, ferr_a}, 32'h0);
      chk("rst_perr",  {31'd0, perr_a}, 32'h0);
      chk("rst_busy",  {31'd0, busy_a}, 32'h0);

      rst_n = 1'b1;
      wait_ticks(4);

      // Nominal byte
      d0 = cnt_a;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 16);
      chk("nom_done_cnt", cnt_a - d0, 32'd1);
      chk("nom_data",     {24'd0, data_a}, 32'hA5);
      chk("nom_ferr",     {31'd0, ferr_a}, 32'h0);
      chk("nom_perr",     {31'd0, perr_a}, 32'h0);
      chk("nom_busy",     {31'd0, busy_a}, 32'h0);

      // Back-to-back frames, no idle gap
      d0 = cnt_a;
      send_frame(1'b0, 8'h00, 1'b0, 1'b1, 16);
      chk("b2b_cnt0",  cnt_a - d0, 32'd1);
      chk("b2b_data0", {24'd0, data_a}, 32'h00);
      send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 16);
      chk("b2b_cnt1",  cnt_a - d0, 32'd2);
      chk("b2b_data1", {24'd0, data_a}, 32'hFF);

      // Framing error: stop bit low past its midpoint, then line released
      d0 = cnt_a;
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 12);
      drive(1'b0, 1'b1, 32);
      chk("ferr_cnt",  cnt_a - d0, 32'd1);
      chk("ferr_data", {24'd0, data_a}, 32'h3C);
      chk("ferr_flag", {31'd0, ferr_a}, 32'h1);
      chk("ferr_busy", {31'd0, busy_a}, 32'h0);
      d0 = cnt_a;
      send_frame(1'b0, 8'h11, 1'b0, 1'b1, 16);
      chk("good_cnt",  cnt_a - d0, 32'd1);
      chk("good_data", {24'd0, data_a}, 32'h11);
      chk("good_ferr", {31'd0, ferr_a}, 32'h0);

      // False start: low for 3 ticks only
      d0 = cnt_a;
      drive(1'b0, 1'b0, 3);
      rx_a = 1'b1;
      @(negedge clk);
      chk("fs_busy_hi", {31'd0, busy_a}, 32'h1);
      wait_ticks(10);
      chk("fs_busy_lo", {31'd0, busy_a}, 32'h0);
      chk("fs_cnt",     cnt_a - d0, 32'd0);
      chk("fs_data",    {24'd0, data_a}, 32'h11);

      // Even parity: 0x07 has three ones, so the parity bit must be 1
      d0 = cnt_p;
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 16);
      chk("par_ok_cnt",  cnt_p - d0, 32'd1);
      chk("par_ok_data", {24'd0, data_p}, 32'h07);
      chk("par_ok_perr", {31'd0, perr_p}, 32'h0);
      d0 = cnt_p;
      send_frame(1'b1, 8'h07, 1'b0, 1'b1, 16);
      chk("par_bad_cnt",  cnt_p - d0, 32'd1);
      chk("par_bad_data", {24'd0, data_p}, 32'h07);
      chk("par_bad_perr", {31'd0, perr_p}, 32'h1);
      chk("par_bad_ferr", {31'd0, ferr_p}, 32'h0);
      d0 = cnt_p;
      send_frame(1'b1, 8'hC3, 1'b0, 1'b1, 16);
      chk("par_c3_data", {24'd0, data_p}, 32'hC3);
      chk("par_c3_perr", {31'd0, perr_p}, 32'h0);

      // Reset pulse in the middle of data bit 4 of 0x5A
      d0 = cnt_a;
      drive(1'b0, 1'b0, 16);
      for (int i = 0; i < 4; i++) drive(1'b0, (i == 1 || i == 3) ? 1'b1 : 1'b0, 16);
      rx_a = 1'b1;
      wait_ticks(8);
      chk("mid_busy_pre", {31'd0, busy_a}, 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_data", {24'd0, data_a}, 32'h0);
      chk("rst_mid_ferr", {31'd0, ferr_a}, 32'h0);
      chk("rst_mid_busy", {31'd0, busy_a}, 32'h0);
      chk("rst_mid_p_data", {24'd0, data_p}, 32'h0);
      wait_ticks(160);
      chk("rst_mid_cnt", cnt_a - d0, 32'd0);
      d0 = cnt_a;
      send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 16);
      chk("post_rst_cnt",  cnt_a - d0, 32'd1);
      chk("post_rst_data", {24'd0, data_a}, 32'h5A);
      chk("post_rst_ferr", {31'd0, ferr_a}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
